if_fetch: RTL and testbench

- Instruction fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the PC and issues word reads on the instruction bus using a request/grant/rvalid handshake.
- Buffers returned words in a small prefetch FIFO and presents one instruction/address pair per cycle to IF/ID.
- Inserts INST_NOP bubbles when no instruction is ready, honours pipeline hold, and flushes on jump.

---
 rtl/if_fetch.sv | 178 +++++++++++++++++
 tb/tb_if_fetch.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Purpose  : Instruction fetch stage feeding the IF/ID pipeline register.
//            Owns the PC, issues word reads over a req/gnt/rvalid bus,
//            buffers returned words in a small prefetch FIFO and presents
//            one instruction/address pair per cycle (INST_NOP when empty).
//            Honours pipeline hold and flushes/redirects on jump.
// Ports    : clk            core clock
//            rst            asynchronous active-low reset
//            jump_flag_i    redirect request from EX
//            jump_addr_i    redirect target (bits [1:0] ignored)
//            hold_flag_i    pipeline hold code (>= 1 stalls IF)
//            ibus_req_o     read request
//            ibus_addr_o    word address of the request
//            ibus_gnt_i     request accepted this cycle
//            ibus_rvalid_i  read data valid (in order)
//            ibus_rdata_i   read data
//            inst_o         instruction to IF/ID
//            inst_addr_o    address of inst_o (0 when no instruction)
//            pc_o           next fetch address (debug)
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter int          DEPTH      = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   input  logic [2:0]  hold_flag_i,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_gnt_i,
   input  logic        ibus_rvalid_i,
   input  logic [31:0] ibus_rdata_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic [31:0] pc_o
);

   localparam int          CW         = $clog2(DEPTH) + 1;
   localparam int          AW         = $clog2(DEPTH);
   localparam logic [31:0] C_INST_NOP = 32'h0000_0001;
   localparam logic [2:0]  C_HOLD_PC  = 3'd1;
   localparam logic [CW:0] C_DEPTH_W  = (CW+1)'(DEPTH);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q,  resp_pc_d;
   logic [CW-1:0] count_q,    count_d;
   logic [CW-1:0] outst_q,    outst_d;
   logic [CW-1:0] discard_q,  discard_d;
   logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
   logic [AW-1:0] wr_ptr_q,   wr_ptr_d;

   logic [31:0]   fifo_data_q [DEPTH];
   logic [31:0]   fifo_addr_q [DEPTH];

   // ---------------------------------------------------------------------
   // Combinational control
   // ---------------------------------------------------------------------
   logic          w_stall;
   logic          w_empty;
   logic [CW:0]   w_inflight;
   logic          w_grant;
   logic          w_resp;
   logic          w_push;
   logic          w_pop;
   logic [31:0]   w_jump_target;
   logic [1:0]    w_unused_jump_lsb;

   assign w_unused_jump_lsb = jump_addr_i[1:0];
   assign w_jump_target     = {jump_addr_i[31:2], 2'b00};

   assign w_stall    = (hold_flag_i >= C_HOLD_PC);
   assign w_empty    = (count_q == '0);
   assign w_inflight = {1'b0, count_q} + {1'b0, outst_q};

   // Occupancy plus outstanding is capped at DEPTH, so a granted request
   // always has a FIFO slot waiting for its response.
   assign ibus_req_o  = rst & ~jump_flag_i & (w_inflight < C_DEPTH_W);
   assign ibus_addr_o = fetch_pc_q;
   assign pc_o        = fetch_pc_q;

   assign w_grant = ibus_req_o & ibus_gnt_i;
   // A response with nothing outstanding is a protocol error and is ignored.
   assign w_resp  = ibus_rvalid_i & (outst_q != '0);
   assign w_push  = w_resp & (discard_q == '0) & ~jump_flag_i;
   assign w_pop   = ~w_empty & ~w_stall & ~jump_flag_i;

   // No bypass: a word pushed this cycle appears on inst_o next cycle.
   assign inst_o      = (w_empty | jump_flag_i) ? C_INST_NOP : fifo_data_q[rd_ptr_q];
   assign inst_addr_o = (w_empty | jump_flag_i) ? 32'h0      : fifo_addr_q[rd_ptr_q];

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      count_d    = count_q;
      outst_d    = outst_q;
      discard_d  = discard_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;

      if (jump_flag_i) begin
         // Flush and redirect. Every request still in flight after this
         // edge returns stale data, so discard mirrors the remaining
         // outstanding count; a response landing now is simply dropped.
         fetch_pc_d = w_jump_target;
         resp_pc_d  = w_jump_target;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         outst_d    = outst_q - CW'(w_resp);
         discard_d  = outst_q - CW'(w_resp);
      end else begin
         if (w_grant) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         outst_d = outst_q + CW'(w_grant) - CW'(w_resp);
         if (w_resp && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
         end
         if (w_push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + AW'(1);
         end
         if (w_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(w_push) - CW'(w_pop);
      end
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q <= RESET_ADDR;
         resp_pc_q  <= RESET_ADDR;
         count_q    <= '0;
         outst_q    <= '0;
         discard_q  <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         count_q    <= count_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // FIFO storage needs no reset: entries are only read while count_q > 0.
   always_ff @(posedge clk) begin
      if (w_push) begin
         fifo_data_q[wr_ptr_q] <= ibus_rdata_i;
         fifo_addr_q[wr_ptr_q] <= resp_pc_q;
      end
   end

`ifndef SYNTHESIS
   a_rvalid_needs_outstanding: assert property (
      @(posedge clk) disable iff (!rst) ibus_rvalid_i |-> (outst_q != '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Purpose  : Self-checking bench for if_fetch. A bus model with in-order,
//            variable-latency responses serves words from a reference memory;
//            a stream scoreboard tracks the next expected instruction address
//            and the next expected fetch address from the fetch rules.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_if_fetch;

   localparam logic [31:0] RA    = 32'h0000_0040;
   localparam int          DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h0000_0001;

   logic        clk = 1'b0;
   logic        rst;
   logic        jump_flag_i;
   logic [31:0] jump_addr_i;
   logic [2:0]  hold_flag_i;
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_gnt_i;
   logic        ibus_rvalid_i;
   logic [31:0] ibus_rdata_i;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic [31:0] pc_o;

   if_fetch #(.RESET_ADDR(RA), .DEPTH(DEPTH)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .jump_flag_i   (jump_flag_i),
      .jump_addr_i   (jump_addr_i),
      .hold_flag_i   (hold_flag_i),
      .ibus_req_o    (ibus_req_o),
      .ibus_addr_o   (ibus_addr_o),
      .ibus_gnt_i    (ibus_gnt_i),
      .ibus_rvalid_i (ibus_rvalid_i),
      .ibus_rdata_i  (ibus_rdata_i),
      .inst_o        (inst_o),
      .inst_addr_o   (inst_addr_o),
      .pc_o          (pc_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          ready;
   } pend_t;

   pend_t       pend_q[$];
   int          cyc, last_ready, gnt_pct, lat_min, lat_max, popped;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [2:0]  hold_now;
   logic        jump_now;
   logic [31:0] jump_addr;
   logic [31:0] exp_addr, exp_issue;
   logic [31:0] obs_inst, obs_iaddr, obs_addr, obs_pc;
   logic        obs_req;
   logic        seen;

   // Reference memory: low bits 2'b11 keep every word distinct from INST_NOP.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[31:2] ^ 30'h2A5A_1234, 2'b11};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One bus cycle: drive inputs just after the edge, sample mid-cycle,
   // update the bus model and scoreboard, then advance past the next edge.
   task automatic step();
      int ready;
      ibus_gnt_i = (int'($urandom_range(99)) < gnt_pct);
      if (pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
         ibus_rvalid_i = 1'b1;
         ibus_rdata_i  = mem_word(pend_q[0].addr);
      end else begin
         ibus_rvalid_i = 1'b0;
         ibus_rdata_i  = $urandom;
      end
      jump_flag_i = jump_now;
      jump_addr_i = jump_addr;
      hold_flag_i = hold_now;
      #4;
      obs_req   = ibus_req_o;
      obs_addr  = ibus_addr_o;
      obs_inst  = inst_o;
      obs_iaddr = inst_addr_o;
      obs_pc    = pc_o;

      if (ibus_rvalid_i) void'(pend_q.pop_front());
      if (obs_req && ibus_gnt_i) begin
         check_eq("issue_addr", obs_addr, exp_issue);
         exp_issue = exp_issue + 32'd4;
         ready = cyc + int'($urandom_range(lat_max, lat_min));
         if (ready <= last_ready) ready = last_ready + 1;
         last_ready = ready;
         pend_q.push_back('{addr: obs_addr, ready: ready});
      end

      if (jump_now) begin
         check_eq("jump_nop", obs_inst, NOP);
         check_eq("jump_noreq", {31'b0, obs_req}, 32'd0);
         exp_addr  = {jump_addr[31:2], 2'b00};
         exp_issue = {jump_addr[31:2], 2'b00};
      end else if (obs_inst !== NOP) begin
         check_eq("inst_addr", obs_iaddr, exp_addr);
         check_eq("inst_data", obs_inst, mem_word(exp_addr));
         if (hold_now == 3'd0) begin
            exp_addr = exp_addr + 32'd4;
            popped++;
         end
      end else begin
         check_eq("empty_addr", obs_iaddr, 32'h0);
      end

      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      rst = 1'b0; jump_flag_i = 1'b0; jump_addr_i = '0; hold_flag_i = '0;
      ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = '0;
      gnt_pct = 100; lat_min = 1; lat_max = 1; hold_now = '0; jump_now = 1'b0;
      jump_addr = '0; exp_addr = RA; exp_issue = RA; cyc = 0; last_ready = 0; popped = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_req",   {31'b0, ibus_req_o}, 32'd0);
      check_eq("rst_addr",  ibus_addr_o, RA);
      check_eq("rst_inst",  inst_o, NOP);
      check_eq("rst_iaddr", inst_addr_o, 32'h0);
      check_eq("rst_pc",    pc_o, RA);
      rst = 1'b1;

      // Zero-wait bus after reset release
      step(); check_eq("t1_c0_inst", obs_inst, NOP); check_eq("t1_c0_addr", obs_addr, RA);
              check_eq("t1_c0_req", {31'b0, obs_req}, 32'd1);
      step(); check_eq("t1_c1_inst", obs_inst, NOP); check_eq("t1_c1_addr", obs_addr, RA + 32'd4);
      step(); check_eq("t1_c2_iaddr", obs_iaddr, RA); check_eq("t1_c2_inst", obs_inst, mem_word(RA));

      // Hold for 3 cycles: head stays, request stops once the FIFO fills
      hold_now = 3'd2;
      step(); check_eq("t2_h0_iaddr", obs_iaddr, RA + 32'd4); check_eq("t2_h0_req", {31'b0, obs_req}, 32'd1);
      step(); check_eq("t2_h1_iaddr", obs_iaddr, RA + 32'd4);
      step(); check_eq("t2_h2_iaddr", obs_iaddr, RA + 32'd4); check_eq("t2_h2_req", {31'b0, obs_req}, 32'd0);
      hold_now = 3'd0;
      step(); check_eq("t2_r0_iaddr", obs_iaddr, RA + 32'd4);
      step(); check_eq("t2_r1_iaddr", obs_iaddr, RA + 32'd8);

      // Jump with two requests outstanding, latency 3
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 20 && pend_q.size() != 2; i++) step();
      check_eq("t3_pend2", 32'(pend_q.size()), 32'd2);
      jump_now = 1'b1; jump_addr = 32'h0000_0100; step(); jump_now = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         step();
         if (obs_inst !== NOP) begin
            seen = 1'b1;
            check_eq("t3_first_iaddr", obs_iaddr, 32'h0000_0100);
         end
      end
      check_eq("t3_first_seen", {31'b0, seen}, 32'd1);

      // Jump to unaligned target while IF/ID is held
      lat_min = 1; lat_max = 1;
      repeat (4) step();
      hold_now = 3'd3; jump_now = 1'b1; jump_addr = 32'h0000_0203; step(); jump_now = 1'b0;
      step(); check_eq("t4_pc", obs_pc, 32'h0000_0200);
      step(); hold_now = 3'd0;
      repeat (6) step();

      // Address wrap at the top of memory
      jump_now = 1'b1; jump_addr = 32'hFFFF_FFF9; step(); jump_now = 1'b0;
      repeat (16) step();
      check_eq("wrap_progress", {31'b0, (exp_addr >= 32'h8 && exp_addr < 32'h100)}, 32'd1);

      // Randomized bus stalls, holds and jumps
      gnt_pct = 70; lat_min = 1; lat_max = 4; popped = 0;
      for (int i = 0; i < 40000 && popped < 1000; i++) begin
         hold_now  = (int'($urandom_range(99)) < 20) ? 3'($urandom_range(7, 1)) : 3'd0;
         jump_now  = (int'($urandom_range(99)) < 2);
         jump_addr = $urandom;
         step();
         check_eq("inflight_cap", {31'b0, (pend_q.size() <= DEPTH)}, 32'd1);
      end
      hold_now = 3'd0; jump_now = 1'b0;
      check_eq("rand_progress", {31'b0, (popped >= 1000)}, 32'd1);

      // Asynchronous reset with one request outstanding
      gnt_pct = 0; lat_min = 4; lat_max = 4;
      for (int i = 0; i < 20 && pend_q.size() != 0; i++) step();
      repeat (3) step();
      gnt_pct = 100; step(); gnt_pct = 0;
      check_eq("t6_pend1", 32'(pend_q.size()), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check_eq("t6_req",   {31'b0, ibus_req_o}, 32'd0);
      check_eq("t6_addr",  ibus_addr_o, RA);
      check_eq("t6_pc",    pc_o, RA);
      check_eq("t6_inst",  inst_o, NOP);
      check_eq("t6_iaddr", inst_addr_o, 32'h0);
      pend_q.delete();
      ibus_rvalid_i = 1'b0;
      last_ready = 0; exp_addr = RA; exp_issue = RA;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      gnt_pct = 100; lat_min = 1; lat_max = 1; popped = 0;
      repeat (10) step();
      check_eq("t6_restart", {31'b0, (popped >= 3)}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
